i2c_target_rx_axis: RTL



---
 rtl/axis_if.sv | 27 ++
 rtl/i2c_target_rx_axis.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_if.sv
// AXI-Stream carrier shared by the I2C receiver and its consumer.
//   tdata  : DATA_WIDTH-bit payload, driven by the master
//   tvalid : payload present, driven by the master
//   tready : consumer can take the payload, driven by the slave
// Handshake: a beat transfers on every rising clk edge where tvalid and tready
// are both high. Once tvalid is raised, the master holds it and keeps tdata
// stable until that transfer cycle. tready may change freely and never gates
// the raising of tvalid.
interface axis_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/i2c_target_rx_axis.sv
// Write-only I2C target receiver. SCL/SDA are oversampled with clk and
// START/STOP are decoded. A write to OWN_ADDR is acknowledged, and the data
// bytes are packed MSB-first into AXIS_DATA_WIDTH words on m_axis.
// Ports:
//   clk, arstn    : system clock (at least 4x SCL), async active-low reset
//   scl_i, sda_i  : raw asynchronous I2C bus lines
//   sda_oe        : 1 pulls SDA low (ACK), 0 releases it
//   m_axis        : AXI-Stream master, one output register, no FIFO
//   busy          : high from an address match until STOP
//   overflow_err  : 1-cycle pulse when a finished word is dropped (NACKed)
//   partial_err   : 1-cycle pulse when STOP/Sr discards buffered bytes
//   state_o       : current FSM state, for debug/observation
module i2c_target_rx_axis #(
    parameter int                        I2C_ADDR_WIDTH  = 7,
    parameter int                        I2C_DATA_WIDTH  = 8,
    parameter int                        AXIS_DATA_WIDTH = 16,
    parameter logic [I2C_ADDR_WIDTH-1:0] OWN_ADDR        = 7'h50,
    parameter int                        SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    axis_if.master     m_axis,
    output logic       busy,
    output logic       overflow_err,
    output logic       partial_err,
    output logic [2:0] state_o
);
    localparam int BYTES_PER_WORD = AXIS_DATA_WIDTH / I2C_DATA_WIDTH;
    localparam int BYTE_CNT_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int BIT_CNT_W      = $clog2(I2C_DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ACK_ADDR  = 3'd2,
        DATA      = 3'd3,
        ACK_DATA  = 3'd4,
        WAIT_STOP = 3'd5
    } state_t;

    // The synchronizers reset to the idle-bus level (both lines high).
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    logic start_det, stop_det, scl_rise, scl_fall;
    assign start_det = scl_s && scl_prev_q && sda_prev_q && !sda_s;
    assign stop_det  = scl_s && scl_prev_q && !sda_prev_q && sda_s;
    assign scl_rise  = scl_s && !scl_prev_q;
    assign scl_fall  = !scl_s && scl_prev_q;

    state_t                      state_q, state_d;
    logic [BIT_CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [I2C_DATA_WIDTH-2:0]   shift_q, shift_d;
    logic [AXIS_DATA_WIDTH-1:0]  pack_q, pack_d;
    logic [AXIS_DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic                        tvalid_q, tvalid_d;
    logic                        sda_oe_q, sda_oe_d;
    logic                        busy_q, busy_d;
    logic                        overflow_q, overflow_d;
    logic                        partial_q, partial_d;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            pack_q     <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            partial_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            pack_q     <= pack_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            partial_q  <= partial_d;
        end
    end

    // The byte as it stands once the current SDA bit is shifted in.
    logic [I2C_DATA_WIDTH-1:0] byte_full;
    assign byte_full = {shift_q, sda_s};

    // Pack register with byte_full placed in slot byte_cnt_q (slot 0 = MSBs).
    logic [AXIS_DATA_WIDTH-1:0] pack_merged;
    always_comb begin
        pack_merged = pack_q;
        pack_merged[AXIS_DATA_WIDTH-1 - int'(byte_cnt_q)*I2C_DATA_WIDTH -: I2C_DATA_WIDTH] = byte_full;
    end

    logic last_bit, word_done, out_stalled;
    assign last_bit    = (bit_cnt_q == BIT_CNT_W'(I2C_DATA_WIDTH-1));
    assign word_done   = (byte_cnt_q == BYTE_CNT_W'(BYTES_PER_WORD-1));
    assign out_stalled = tvalid_q && !m_axis.tready;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        pack_d     = pack_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        overflow_d = 1'b0;
        partial_d  = 1'b0;

        // Accepted beat frees the output register; a load below overrides it.
        if (tvalid_q && m_axis.tready) tvalid_d = 1'b0;

        if (start_det || stop_det) begin
            if (byte_cnt_q != '0) partial_d = 1'b1;
            pack_d     = '0;
            byte_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
            sda_oe_d   = 1'b0;
            if (stop_det) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end else begin
                // busy is re-decided by the address byte that follows.
                state_d = ADDR;
            end
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_full[I2C_DATA_WIDTH-2:0];
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit) begin
                            bit_cnt_d = '0;
                            // byte_full LSB is the R/W bit; only writes match.
                            if (byte_full[I2C_DATA_WIDTH-1 -: I2C_ADDR_WIDTH] == OWN_ADDR && !sda_s) begin
                                state_d = ACK_ADDR;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ACK_ADDR, ACK_DATA: begin
                    // First fall ends bit 8 and starts the ACK drive;
                    // the second fall ends the 9th clock.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = DATA;
                        end
                    end
                end
                DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_full[I2C_DATA_WIDTH-2:0];
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit) begin
                            bit_cnt_d = '0;
                            if (word_done) begin
                                pack_d     = '0;
                                byte_cnt_d = '0;
                                if (out_stalled) begin
                                    // No room: NACK by never entering ACK_DATA.
                                    overflow_d = 1'b1;
                                    state_d    = WAIT_STOP;
                                end else begin
                                    tdata_d  = pack_merged;
                                    tvalid_d = 1'b1;
                                    state_d  = ACK_DATA;
                                end
                            end else begin
                                pack_d     = pack_merged;
                                byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                                state_d    = ACK_DATA;
                            end
                        end
                    end
                end
                WAIT_STOP: sda_oe_d = 1'b0;
                default:   state_d  = IDLE;
            endcase
        end
    end

    assign sda_oe        = sda_oe_q;
    assign busy          = busy_q;
    assign overflow_err  = overflow_q;
    assign partial_err   = partial_q;
    assign state_o       = state_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
endmodule
